// File: rtl/text_render.sv
// Text-mode rasteriser: walks the character buffer, fetches 8x8 glyph rows and writes FG/BG pixels to the framebuffer.
// Optional feature: define TEXT_RENDER_INVERSE_EN to treat code[7] as an inverse-video attribute.
module text_render #(
  parameter int          COLS = 40,
  parameter int          ROWS = 24,
  parameter int          FB_W = 320,
  parameter logic [23:0] FG   = 24'hFFFFFF,
  parameter logic [23:0] BG   = 24'h000000
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [9:0]  txt_adr,
  input  logic [7:0]  txt,
  output logic [10:0] font_adr,
  input  logic [7:0]  font_d,
  output logic [15:0] fb_wadr,
  output logic        fb_we,
  output logic [23:0] fb_d
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CADR  = 3'd1,
    CWAIT = 3'd2,
    FADR  = 3'd3,
    FWAIT = 3'd4,
    PIX   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  row_q, row_d;
  logic [7:0]  col_q, col_d;
  logic [2:0]  scan_q, scan_d;
  logic [2:0]  px_q, px_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  glyph_q, glyph_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [9:0]  txt_adr_q, txt_adr_d;
  logic [10:0] font_adr_q, font_adr_d;
  logic [15:0] fb_wadr_q, fb_wadr_d;
  logic        fb_we_q, fb_we_d;
  logic [23:0] fb_d_q, fb_d_d;
  logic        inv_cell;

  function automatic logic [10:0] font_addr(input logic [7:0] code, input logic [2:0] scan);
`ifdef TEXT_RENDER_INVERSE_EN
    return {1'b0, code[6:0], scan};
`else
    return {code, scan};
`endif
  endfunction

  // Intermediates are 32 bits wide so the product never wraps before the final truncation.
  function automatic logic [15:0] pix_addr(input logic [7:0] row, input logic [2:0] scan,
                                           input logic [7:0] col, input logic [2:0] px);
    return 16'((32'(row) * 32'd8 + 32'(scan)) * 32'(FB_W) + 32'(col) * 32'd8 + 32'(px));
  endfunction

  function automatic logic [23:0] pix_color(input logic bit_on, input logic inv);
    return (bit_on ^ inv) ? FG : BG;
  endfunction

`ifdef TEXT_RENDER_INVERSE_EN
  assign inv_cell = code_q[7];
`else
  assign inv_cell = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    scan_d     = scan_q;
    px_d       = px_q;
    code_d     = code_q;
    glyph_d    = glyph_q;
    done_d     = 1'b0;
    txt_adr_d  = txt_adr_q;
    font_adr_d = font_adr_q;
    fb_wadr_d  = fb_wadr_q;
    fb_we_d    = 1'b0;
    fb_d_d     = fb_d_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CADR;
          row_d     = '0;
          col_d     = '0;
          scan_d    = '0;
          px_d      = '0;
          txt_adr_d = '0;
        end
      end
      CADR: state_d = CWAIT;
      CWAIT: begin
        code_d     = txt;
        font_adr_d = font_addr(txt, scan_q);
        state_d    = FADR;
      end
      FADR: state_d = FWAIT;
      // The first pixel is taken straight from the font port; the glyph register feeds the rest.
      FWAIT: begin
        glyph_d   = font_d;
        px_d      = '0;
        fb_we_d   = 1'b1;
        fb_wadr_d = pix_addr(row_q, scan_q, col_q, 3'd0);
        fb_d_d    = pix_color(font_d[7], inv_cell);
        state_d   = PIX;
      end
      PIX: begin
        if (px_q != 3'd7) begin
          px_d      = px_q + 3'd1;
          fb_we_d   = 1'b1;
          fb_wadr_d = pix_addr(row_q, scan_q, col_q, px_d);
          fb_d_d    = pix_color(glyph_q[3'd7 - px_d], inv_cell);
        end else if (scan_q != 3'd7) begin
          scan_d     = scan_q + 3'd1;
          font_adr_d = font_addr(code_q, scan_d);
          state_d    = FADR;
        end else if (row_q == 8'(ROWS - 1) && col_q == 8'(COLS - 1)) begin
          row_d   = '0;
          col_d   = '0;
          scan_d  = '0;
          px_d    = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          scan_d = '0;
          if (col_q == 8'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + 8'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
          txt_adr_d = 10'(32'(row_d) * 32'(COLS) + 32'(col_d));
          state_d   = CADR;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      scan_q     <= '0;
      px_q       <= '0;
      code_q     <= '0;
      glyph_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      txt_adr_q  <= '0;
      font_adr_q <= '0;
      fb_wadr_q  <= '0;
      fb_we_q    <= 1'b0;
      fb_d_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      scan_q     <= scan_d;
      px_q       <= px_d;
      code_q     <= code_d;
      glyph_q    <= glyph_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      txt_adr_q  <= txt_adr_d;
      font_adr_q <= font_adr_d;
      fb_wadr_q  <= fb_wadr_d;
      fb_we_q    <= fb_we_d;
      fb_d_q     <= fb_d_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign txt_adr  = txt_adr_q;
  assign font_adr = font_adr_q;
  assign fb_wadr  = fb_wadr_q;
  assign fb_we    = fb_we_q;
  assign fb_d     = fb_d_q;

endmodule

// File: tb/tb_text_render.sv
// Directed bench for text_render: one full pass against a raster-order pixel model, back-to-back restart, mid-pass reset.
module tb_text_render;

  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000000;

  logic        CLOCK_50 = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [9:0]  txt_adr;
  logic [7:0]  txt;
  logic [10:0] font_adr;
  logic [7:0]  font_d;
  logic [15:0] fb_wadr;
  logic        fb_we;
  logic [23:0] fb_d;

  always #5 CLOCK_50 = ~CLOCK_50;

  text_render dut (
    .CLOCK_50(CLOCK_50),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .txt_adr(txt_adr),
    .txt(txt),
    .font_adr(font_adr),
    .font_d(font_d),
    .fb_wadr(fb_wadr),
    .fb_we(fb_we),
    .fb_d(fb_d)
  );

  logic [7:0] textMem [0:1023];
  logic [7:0] fontMem [0:2047];

  // Synchronous-read memories with one cycle of latency.
  always @(posedge CLOCK_50) begin
    txt    <= textMem[txt_adr];
    font_d <= fontMem[font_adr];
  end

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstVal, input logic startVal);
    @(posedge CLOCK_50);
    #1;
    rst   = rstVal;
    start = startVal;
  endtask

  function automatic logic [23:0] expPixel(input int r, input int c, input int s, input int p);
    logic [7:0]  code;
    logic [7:0]  g;
    logic        inv;
    logic [10:0] fa;
    code = textMem[r * 40 + c];
`ifdef TEXT_RENDER_INVERSE_EN
    inv = code[7];
    fa  = {1'b0, code[6:0], 3'(s)};
`else
    inv = 1'b0;
    fa  = {code, 3'(s)};
`endif
    g = fontMem[fa];
    return (g[7 - p] ^ inv) ? FG : BG;
  endfunction

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  logic        monOn = 1'b0;
  int          mRow = 0, mCol = 0, mScan = 0, mPx = 0;
  int          wrCount = 0, addrErrs = 0, dataErrs = 0, doneCount = 0;
  int          firstBusy = -1, firstWe = -1, lastWe = -1, doneCyc = -1;
  int          expAddr;
  logic [23:0] fbSeen [0:65535];

  // Raster-order model of the expected write stream, sampled on the falling edge.
  always @(negedge CLOCK_50) begin
    if (monOn) begin
      if (busy && firstBusy < 0) firstBusy = cyc;
      if (fb_we) begin
        if (firstWe < 0) firstWe = cyc;
        lastWe  = cyc;
        expAddr = (mRow * 8 + mScan) * 320 + mCol * 8 + mPx;
        if (fb_wadr !== 16'(expAddr)) addrErrs++;
        if (fb_d !== expPixel(mRow, mCol, mScan, mPx)) dataErrs++;
        fbSeen[fb_wadr] = fb_d;
        wrCount++;
        mPx++;
        if (mPx == 8) begin
          mPx = 0;
          mScan++;
          if (mScan == 8) begin
            mScan = 0;
            mCol++;
            if (mCol == 40) begin
              mCol = 0;
              mRow++;
            end
          end
        end
      end
      if (done) begin
        doneCount++;
        if (doneCyc < 0) doneCyc = cyc;
      end
    end
  end

  logic timedOut;
  logic gotWe;

  initial begin
    for (int i = 0; i < 1024; i++) textMem[i] = 8'h00;
    for (int i = 0; i < 2048; i++) fontMem[i] = 8'h00;
    textMem[0]   = 8'h41;
    textMem[1]   = 8'hC1;
    textMem[41]  = 8'h41;
    textMem[959] = 8'h42;
    fontMem[{8'h41, 3'd0}] = 8'b1000_0001;
    fontMem[{8'h42, 3'd7}] = 8'hFF;

    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_fb_we", 32'(fb_we), 0);
    checkOutput("rst_txt_adr", 32'(txt_adr), 0);
    checkOutput("rst_font_adr", 32'(font_adr), 0);
    checkOutput("rst_fb_wadr", 32'(fb_wadr), 0);
    checkOutput("rst_fb_d", 32'(fb_d), 0);

    @(negedge CLOCK_50);
    rst   = 1'b1;
    monOn = 1'b1;
    applyStimulus(1'b1, 1'b1);

    timedOut = 1'b1;
    for (int i = 0; i < 80000; i++) begin
      @(posedge CLOCK_50);
      #1;
      if (done) begin
        timedOut = 1'b0;
        break;
      end
    end
    checkOutput("pass1_timeout", 32'(timedOut), 0);
    checkOutput("done_busy", 32'(busy), 0);
    checkOutput("done_fb_we", 32'(fb_we), 0);

    @(posedge CLOCK_50);
    #1;
    monOn = 1'b0;
    checkOutput("restart_busy", 32'(busy), 1);
    checkOutput("restart_done", 32'(done), 0);
    checkOutput("restart_txt_adr", 32'(txt_adr), 0);

    checkOutput("pass_len", 32'(doneCyc - firstBusy), 78720);
    checkOutput("first_we_lat", 32'(firstWe - firstBusy), 4);
    checkOutput("done_after_last", 32'(doneCyc - lastWe), 1);
    checkOutput("write_count", 32'(wrCount), 61440);
    checkOutput("addr_errs", 32'(addrErrs), 0);
    checkOutput("data_errs", 32'(dataErrs), 0);
    checkOutput("done_count", 32'(doneCount), 1);
    checkOutput("px_addr0", 32'(fbSeen[0]), 32'(FG));
    for (int a = 1; a <= 6; a++) checkOutput($sformatf("px_addr%0d", a), 32'(fbSeen[a]), 32'(BG));
    checkOutput("px_addr7", 32'(fbSeen[7]), 32'(FG));
    checkOutput("px_addr320", 32'(fbSeen[320]), 32'(BG));
    checkOutput("px_addr61431", 32'(fbSeen[61431]), 32'(BG));
    for (int a = 61432; a <= 61439; a++) checkOutput($sformatf("px_addr%0d", a), 32'(fbSeen[a]), 32'(FG));
`ifdef TEXT_RENDER_INVERSE_EN
    checkOutput("inv_addr8", 32'(fbSeen[8]), 32'(BG));
    checkOutput("inv_addr9", 32'(fbSeen[9]), 32'(FG));
    checkOutput("inv_addr328", 32'(fbSeen[328]), 32'(FG));
`else
    checkOutput("c1_addr8", 32'(fbSeen[8]), 32'(BG));
    checkOutput("c1_addr9", 32'(fbSeen[9]), 32'(BG));
    checkOutput("c1_addr328", 32'(fbSeen[328]), 32'(BG));
`endif

    gotWe = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLOCK_50);
      #1;
      if (fb_we) begin
        gotWe = 1'b1;
        break;
      end
    end
    checkOutput("pass2_we_seen", 32'(gotWe), 1);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    #1;
    checkOutput("midrst_fb_we", 32'(fb_we), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_done", 32'(done), 0);
    checkOutput("midrst_txt_adr", 32'(txt_adr), 0);
    checkOutput("midrst_font_adr", 32'(font_adr), 0);
    checkOutput("midrst_fb_wadr", 32'(fb_wadr), 0);
    checkOutput("midrst_fb_d", 32'(fb_d), 0);

    @(negedge CLOCK_50);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("p3_cadr_busy", 32'(busy), 1);
    checkOutput("p3_cadr_txt_adr", 32'(txt_adr), 0);
    repeat (2) @(posedge CLOCK_50);
    #1;
    checkOutput("p3_font_adr", 32'(font_adr), 32'h208);
    repeat (2) @(posedge CLOCK_50);
    #1;
    checkOutput("p3_we0", 32'(fb_we), 1);
    checkOutput("p3_wadr0", 32'(fb_wadr), 0);
    checkOutput("p3_d0", 32'(fb_d), 32'(FG));
    @(posedge CLOCK_50);
    #1;
    checkOutput("p3_wadr1", 32'(fb_wadr), 1);
    checkOutput("p3_d1", 32'(fb_d), 32'(BG));
    repeat (79) @(posedge CLOCK_50);
    #1;
`ifdef TEXT_RENDER_INVERSE_EN
    checkOutput("p3_cell1_font_adr", 32'(font_adr), 32'h208);
`else
    checkOutput("p3_cell1_font_adr", 32'(font_adr), 32'h608);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_render.md
# text_render

Text-mode rasteriser that sits directly upstream of `vdp`: it walks a 40x24 character buffer, looks up each glyph in an 8x8 font ROM and writes 24-bit pixels into the framebuffer write port that `vdp` scans out. One render pass is started by a pulse and repaints the whole 320x192 text area. All memories are external, synchronous-read, with one-cycle latency.

## Interface
- `COLS`, 40, characters per row
- `ROWS`, 24, character rows
- `FB_W`, 320, framebuffer line pitch in pixels (must be at least COLS*8)
- `FG`, 24'hFFFFFF, foreground pixel value
- `BG`, 24'h000000, background pixel value

Ports:
- `CLOCK_50`  in  1  sole clock; all state and memory ports are clocked by it
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a render pass (sampled in IDLE only)
- `busy`  out  1  pass in progress
- `done`  out  1  one-cycle pulse at end of pass
- `txt_adr`  out  10  text buffer address = row*COLS+col
- `txt`  in  8  character code, valid the cycle after `txt_adr`
- `font_adr`  out  11  {code[7:0], scanline[2:0]}
- `font_d`  in  8  glyph row, valid the cycle after `font_adr`; bit 7 = leftmost pixel
- `fb_wadr`  out  16  framebuffer write address
- `fb_we`  out  1  framebuffer write strobe
- `fb_d`  out  24  pixel data

## Operation
- FSM states: IDLE, CADR, CWAIT, FADR, FWAIT, PIX.
- IDLE:
  - `start`=1 → CADR with row=col=scan=px=0.
  - Otherwise stay in IDLE.
- CADR: `txt_adr` = row*COLS+col → CWAIT.
- CWAIT: latch `txt` into the code register → FADR.
- FADR: drive `font_adr` = {code, scan} → FWAIT.
- FWAIT: latch `font_d` into the shift register → PIX.
- PIX, 8 cycles, px = 0..7:
  - `fb_we`=1.
  - `fb_wadr` = (row*8+scan)*FB_W + col*8 + px, truncated to 16 bits.
  - `fb_d` = glyph bit (7−px) ? FG : BG.
- After px=7:
  - scan<7: scan++ → FADR.
  - scan=7, cell not last: scan=0, then advance col. Col wraps at COLS−1 to 0 and increments row. → CADR.
  - Last cell (row=ROWS−1, col=COLS−1): → IDLE with `done`=1.
- `start` outside IDLE is ignored; no queuing.
- `busy`=1 in every state except IDLE.
- Address arithmetic uses at least 17-bit intermediates before truncation.
- Reset, asserted at any time including mid-pass:
  - Immediately forces IDLE.
  - Clears all counters.
  - All outputs go to 0, including `fb_we`. No partial write completes.

## Timing
- All outputs are registered.
- `start` high at edge k → `busy`=1 and CADR from cycle k+1.
- Per cell: 2 cycles for the character fetch, plus 8 × (2 font-fetch cycles + 8 pixel cycles) = 82 cycles.
- First `fb_we` falls 4 cycles after the first CADR cycle.
- Pass length:
  - ROWS*COLS*82 cycles from the first CADR cycle to the `done` cycle.
  - Defaults: 960*82 = 78720 cycles.
- `done` and `busy`=0 appear together in the cycle after the last pixel write.
- `start` may be asserted in that same cycle to begin a new pass.
- Writes are strictly sequential in raster order within each cell, one per PIX cycle, with no gaps inside a PIX burst.

## Configuration
- `TEXT_RENDER_INVERSE_EN` defined:
  - `code[7]` is an inverse-video attribute.
  - `font_adr` = {1'b0, code[6:0], scan}.
  - When `code[7]`=1, FG and BG are swapped for that cell.
- Undefined:
  - The full 8-bit code indexes the font.
  - No inversion.

## Test plan
- Reset mid-pass: assert `rst` low during PIX → same cycle `fb_we`=0 and `busy`=0; all outputs 0; the next `start` begins again at cell 0.
- Blank buffer, font all 0 → 61440 writes of 24'h000000 to addresses 0..61439; `done` arrives exactly 78720 cycles after the first CADR cycle.
- Cell (0,0)=8'h41, font row 0 for 0x41 = 8'b10000001, all else 0 → writes to addr 0 and addr 7 carry FG; addrs 1..6 carry BG; scan 1 begins at addr 320.
- Last cell (23,39): glyph scan 7 = 8'hFF → addrs 61432..61439 = FG; `done` 1 cycle after the write to 61439.
- `start` held high throughout a pass → no restart while busy; a second pass starts the cycle after `done`.
- `TEXT_RENDER_INVERSE_EN`, code 8'hC1 → `font_adr` = {8'h41, scan}; glyph 1-bits written as BG and 0-bits as FG.
